// File: rtl/isa_pkg.sv
// ISA definitions shared by the fetch unit and the control decoder.
// Holds the fixed opcode encodings, instruction field bit positions,
// the sliced-field struct and the opcode legality check.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_ADD      = 5'd0,
        OP_SUB      = 5'd1,
        OP_MUL      = 5'd2,
        OP_AND      = 5'd3,
        OP_OR       = 5'd4,
        OP_LBD      = 5'd10,
        OP_LDW      = 5'd11,
        OP_STB      = 5'd12,
        OP_STW      = 5'd13,
        OP_MOV      = 5'd14,
        OP_BEQ      = 5'd20,
        OP_JUMP     = 5'd21,
        OP_TLBWRITE = 5'd30,
        OP_IRET     = 5'd31
    } opcode_t;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 27;
    localparam int unsigned RD_MSB  = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS_MSB  = 21;
    localparam int unsigned RS_LSB  = 17;
    localparam int unsigned RT_MSB  = 16;
    localparam int unsigned RT_LSB  = 12;
    localparam int unsigned IMM_MSB = 11;
    localparam int unsigned IMM_LSB = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [11:0] imm;
    } instr_fields_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
            OP_LBD, OP_LDW, OP_STB, OP_STW, OP_MOV,
            OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the instruction fetch unit.
//   imem_*     : req/ack fetch channel to instruction memory
//   instr_*    : valid/ready channel carrying sliced fields to the decoder
//   redirect_* : taken branch/jump target from the execute stage
// master = fetch unit side, slave = environment (memory/decoder/execute) side.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [4:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [11:0]       imm;
    logic [ADDR_W-1:0] pc_out;
    logic              illegal_op;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, op, rd, rs, rt, imm, pc_out, illegal_op,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, op, rd, rs, rt, imm, pc_out, illegal_op,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_slicer.sv
// Combinational instruction slicer: splits a 32-bit instruction word into
// op/rd/rs/rt/imm and flags opcodes outside the defined set.
//   word    : raw instruction word from memory
//   fields  : sliced fields (imm raw, not extended)
//   illegal : op is not a defined opcode
module instr_slicer
    import isa_pkg::*;
(
    input  logic [31:0]   word,
    output instr_fields_t fields,
    output logic          illegal
);
    always_comb begin
        fields.op  = word[OP_MSB:OP_LSB];
        fields.rd  = word[RD_MSB:RD_LSB];
        fields.rs  = word[RS_MSB:RS_LSB];
        fields.rt  = word[RT_MSB:RT_LSB];
        fields.imm = word[IMM_MSB:IMM_LSB];
        illegal    = !is_legal_op(word[OP_MSB:OP_LSB]);
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Owns the PC, issues one outstanding req/ack fetch
// at a time, registers the sliced fields and offers them to the decoder over
// valid/ready. A redirect from execute replaces the PC and kills any fetch
// still in flight.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fetch unit side of instr_fetch_if (memory, decoder, redirect)
module instr_fetch
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t            state;
    logic              running;   // low only during and right out of reset
    logic              kill;      // outstanding fetch belongs to a redirected-away path
    logic [ADDR_W-1:0] pc;        // next/current PC, may run ahead of addr on redirect
    logic [ADDR_W-1:0] addr;      // address of the outstanding request
    logic [ADDR_W-1:0] pc_out_q;
    instr_fields_t     fields_d;
    instr_fields_t     fields_q;
    logic              illegal_d;
    logic              illegal_q;

    instr_slicer u_slicer (
        .word    (bus.imem_rdata),
        .fields  (fields_d),
        .illegal (illegal_d)
    );

    // A redirect arriving while a request is pending only updates pc and
    // marks the request as killed; addr stays put until that request is
    // acked so the memory sees a stable req/addr pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            running   <= 1'b0;
            kill      <= 1'b0;
            pc        <= PC_INIT;
            addr      <= PC_INIT;
            pc_out_q  <= PC_INIT;
            fields_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            running <= 1'b1;
            case (state)
                FETCH: begin
                    if (running) begin
                        if (bus.imem_ack) begin
                            if (kill || bus.redirect_valid) begin
                                pc   <= bus.redirect_valid ? bus.redirect_pc : pc;
                                addr <= bus.redirect_valid ? bus.redirect_pc : pc;
                                kill <= 1'b0;
                            end else begin
                                fields_q  <= fields_d;
                                illegal_q <= illegal_d;
                                pc_out_q  <= pc;
                                state     <= VALID;
                            end
                        end else if (bus.redirect_valid) begin
                            pc   <= bus.redirect_pc;
                            kill <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (bus.redirect_valid) begin
                        pc    <= bus.redirect_pc;
                        addr  <= bus.redirect_pc;
                        state <= FETCH;
                    end else if (bus.instr_ready) begin
                        pc    <= pc + ADDR_W'(1);
                        addr  <= pc + ADDR_W'(1);
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_req    = running && (state == FETCH);
    assign bus.imem_addr   = addr;
    // Redirect masks valid so no transfer can complete in a redirect cycle.
    assign bus.instr_valid = (state == VALID) && !bus.redirect_valid;
    assign bus.op          = fields_q.op;
    assign bus.rd          = fields_q.rd;
    assign bus.rs          = fields_q.rs;
    assign bus.rt          = fields_q.rt;
    assign bus.imm         = fields_q.imm;
    assign bus.pc_out      = pc_out_q;
    assign bus.illegal_op  = illegal_q;
endmodule
